pet_uart_tx: RTL and testbench



---
 rtl/pet_uart_pkg.sv | 17 +
 rtl/pet_uart_tx_fifo.sv | 64 ++++++
 rtl/pet_uart_tx.sv | 126 ++++++++++++
 tb/tb_pet_uart_tx.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pet_uart_pkg.sv
// Shared PET UART definitions: FSM state encoding (common with the receiver),
// default bit timing and frame lengths in bit times.
package pet_uart_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 434;  // 50 MHz / 115200
  localparam int FRAME_BITS_8N1       = 10;
  localparam int FRAME_BITS_8E1       = 11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

endpackage

// File: rtl/pet_uart_tx_fifo.sv
// Synchronous TX byte FIFO with occupancy count; power-of-two depth.
// Latency: head visible on rd_dat the cycle after the write.
// Backpressure: wr_rdy is a flop of (count != depth); writes while full are dropped.
module pet_uart_tx_fifo #(
  parameter int DEPTH_LOG2 = 2,
  parameter int WIDTH      = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_vld,
  input  logic [WIDTH-1:0]      wr_dat,
  output logic                  wr_rdy,
  output logic                  rd_vld,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      rd_dat,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int                DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count_nxt;
  logic                  push;
  logic                  pop;

  assign push   = wr_vld && wr_rdy;
  assign pop    = rd_en && (count != '0);
  assign rd_vld = (count != '0);
  assign rd_dat = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (push && !pop)
      count_nxt = count + 1'b1;
    else if (pop && !push)
      count_nxt = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= wr_dat;
  end

  // Pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      wr_rdy <= 1'b1;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      count  <= count_nxt;
      wr_rdy <= (count_nxt != FULL);
    end
  end

endmodule

// File: rtl/pet_uart_tx.sv
// PET UART transmitter: FIFO-buffered 8N1 serial out (8E1 when PET_UART_TX_PARITY_EN is defined).
// Latency: push at edge N -> pop at N+1 -> txd start bit from N+2; one idle clock between frames.
// Backpressure: tx_ready low while the FIFO is full.
module pet_uart_tx
  import pet_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT    = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH_LOG2 = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [7:0]               tx_data,
  input  logic                     tx_valid,
  output logic                     tx_ready,
  output logic                     txd,
  output logic                     tx_busy,
  output logic [FIFO_DEPTH_LOG2:0] fifo_count
);

  localparam int                BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  uart_state_e       state;
  uart_state_e       state_nxt;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_idx;
  logic [7:0]        shift_q;
  logic              txd_q;
  logic              txd_nxt;
  logic              bit_done;
  logic              pop;
  logic              fifo_vld;
  logic [7:0]        fifo_dat;
`ifdef PET_UART_TX_PARITY_EN
  logic              parity_q;
`endif

  pet_uart_tx_fifo #(
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2),
    .WIDTH      (8)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_vld  (tx_valid),
    .wr_dat  (tx_data),
    .wr_rdy  (tx_ready),
    .rd_vld  (fifo_vld),
    .rd_en   (pop),
    .rd_dat  (fifo_dat),
    .count   (fifo_count)
  );

  assign bit_done = (baud_cnt == BAUD_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (fifo_vld) state_nxt = START;
      START: if (bit_done) state_nxt = DATA;
`ifdef PET_UART_TX_PARITY_EN
      DATA:   if (bit_done && bit_idx == 3'd7) state_nxt = PARITY;
      PARITY: if (bit_done) state_nxt = STOP;
`else
      DATA:  if (bit_done && bit_idx == 3'd7) state_nxt = STOP;
`endif
      STOP:  if (bit_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // txd_nxt is decoded from the current state and registered, so the line lags the FSM by one clock.
  always_comb begin
    pop     = 1'b0;
    txd_nxt = 1'b1;
    case (state)
      IDLE:   pop     = fifo_vld;
      START:  txd_nxt = 1'b0;
      DATA:   txd_nxt = shift_q[0];
`ifdef PET_UART_TX_PARITY_EN
      PARITY: txd_nxt = parity_q;
`endif
      default: txd_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift_q  <= '0;
      txd_q    <= 1'b1;
`ifdef PET_UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      txd_q <= txd_nxt;
      if (state == IDLE) begin
        baud_cnt <= '0;
        bit_idx  <= '0;
        if (pop) begin
          shift_q  <= fifo_dat;
`ifdef PET_UART_TX_PARITY_EN
          parity_q <= ^fifo_dat;
`endif
        end
      end else begin
        baud_cnt <= bit_done ? '0 : baud_cnt + 1'b1;
        if (state == DATA && bit_done) begin
          shift_q <= {1'b0, shift_q[7:1]};
          bit_idx <= bit_idx + 1'b1;
        end
      end
    end
  end

  assign txd     = txd_q;
  assign tx_busy = (fifo_count != '0) || (state != IDLE);

endmodule

// File: tb/tb_pet_uart_tx.sv
// Directed bench for pet_uart_tx at 4 clocks per bit with a sampling UART receiver model.
`timescale 1ns/1ps
module tb_pet_uart_tx;

  localparam int C    = 4;
  localparam int LOG2 = 2;
`ifdef PET_UART_TX_PARITY_EN
  localparam int NB   = 11;
`else
  localparam int NB   = 10;
`endif

  logic            clk      = 1'b0;
  logic            reset_n  = 1'b0;
  logic [7:0]      tx_data  = 8'h00;
  logic            tx_valid = 1'b0;
  logic            tx_ready;
  logic            txd;
  logic            tx_busy;
  logic [LOG2:0]   fifo_count;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pet_uart_tx #(
    .CLKS_PER_BIT    (C),
    .FIFO_DEPTH_LOG2 (LOG2)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .txd        (txd),
    .tx_busy    (tx_busy),
    .fifo_count (fifo_count)
  );

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Call at a negedge; returns at the negedge following the accepting posedge.
  task automatic push_byte(input logic [7:0] b);
    tx_data  = b;
    tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic uart_rx(output logic [7:0] d, output logic par, output int s,
                         output int peak, output bit ok);
    int   n = 0;
    logic sb;
    logic eb;
    d = '0; par = 1'b0; s = 0; peak = 0; ok = 1'b0;
    do begin
      @(negedge clk);
      n++;
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
    end while (txd !== 1'b0 && n < 400);
    if (txd !== 1'b0) return;
    s = cyc;
    repeat (2) @(negedge clk);
    sb = txd;
    for (int j = 0; j < 8; j++) begin
      repeat (C) @(negedge clk);
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
      d[j] = txd;
    end
    if (NB == 11) begin
      repeat (C) @(negedge clk);
      par = txd;
    end
    repeat (C) @(negedge clk);
    eb = txd;
    ok = (sb === 1'b0) && (eb === 1'b1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (tx_busy !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (tx_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL wait_idle: tx_busy=%b required 0 within 300 clocks", tx_busy);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    vectors++; if (txd !== 1'b1) begin miscompares++; $display("FAIL reset_txd: got %b want 1", txd); end
    vectors++; if (tx_ready !== 1'b1) begin miscompares++; $display("FAIL reset_tx_ready: got %b want 1", tx_ready); end
    vectors++; if (tx_busy !== 1'b0) begin miscompares++; $display("FAIL reset_tx_busy: got %b want 0", tx_busy); end
    vectors++; if (fifo_count !== 3'd0) begin miscompares++; $display("FAIL reset_fifo_count: got %0d want 0", fifo_count); end
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    vectors++; if (txd !== 1'b1 || tx_busy !== 1'b0) begin
      miscompares++; $display("FAIL post_reset_idle: txd=%b busy=%b want 1/0", txd, tx_busy);
    end
  endtask

  task automatic test_single_0x55();
    logic [10:0] exp;
`ifdef PET_UART_TX_PARITY_EN
    exp = 11'b100_1010_1010;
`else
    exp = 11'b010_1010_1010;
`endif
    push_byte(8'h55);
    vectors++; if (fifo_count !== 3'd1 || tx_busy !== 1'b1 || txd !== 1'b1) begin
      miscompares++; $display("FAIL single_m0: count=%0d busy=%b txd=%b want 1/1/1", fifo_count, tx_busy, txd);
    end
    @(negedge clk);
    vectors++; if (fifo_count !== 3'd0 || txd !== 1'b1) begin
      miscompares++; $display("FAIL single_m1: count=%0d txd=%b want 0/1", fifo_count, txd);
    end
    @(negedge clk);
    vectors++; if (txd !== 1'b0) begin miscompares++; $display("FAIL single_start_edge: txd=%b want 0", txd); end
    for (int m = 3; m <= NB * C + 1; m++) begin
      @(negedge clk);
      if ((m - 3) % C == 0 && (m - 3) / C < NB) begin
        vectors++;
        if (txd !== exp[(m - 3) / C]) begin
          miscompares++; $display("FAIL single_bit%0d: txd=%b want %b", (m - 3) / C, txd, exp[(m - 3) / C]);
        end
      end
      if (m == NB * C) begin
        vectors++; if (tx_busy !== 1'b1) begin miscompares++; $display("FAIL single_busy_last_stop: got %b want 1", tx_busy); end
      end
      if (m == NB * C + 1) begin
        vectors++; if (tx_busy !== 1'b0) begin miscompares++; $display("FAIL single_busy_drop: got %b want 0", tx_busy); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d1, d2;
    logic       p1, p2;
    int         s1, s2, pk1, pk2;
    bit         ok1, ok2;
    wait_idle();
    tx_data  = 8'h41;
    tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_data = 8'h0D;
    @(posedge clk);
    #1 tx_valid = 1'b0;
    @(negedge clk);
    vectors++; if (fifo_count !== 3'd1) begin miscompares++; $display("FAIL b2b_push_pop_count: got %0d want 1", fifo_count); end
    uart_rx(d1, p1, s1, pk1, ok1);
    uart_rx(d2, p2, s2, pk2, ok2);
    vectors++; if (d1 !== 8'h41 || !ok1) begin miscompares++; $display("FAIL b2b_byte0: got %h ok=%0d want 41", d1, ok1); end
    vectors++; if (d2 !== 8'h0D || !ok2) begin miscompares++; $display("FAIL b2b_byte1: got %h ok=%0d want 0d", d2, ok2); end
    vectors++; if (s2 - s1 !== NB * C + 1) begin miscompares++; $display("FAIL b2b_spacing: got %0d want %0d", s2 - s1, NB * C + 1); end
    vectors++; if (pk1 !== 1) begin miscompares++; $display("FAIL b2b_count_peak: got %0d want 1", pk1); end
`ifdef PET_UART_TX_PARITY_EN
    vectors++; if (p1 !== 1'b0 || p2 !== 1'b1) begin miscompares++; $display("FAIL b2b_parity: got %b%b want 01", p1, p2); end
`endif
  endtask

  task automatic test_fifo_full();
    logic [7:0] bytes [6];
    int         n;
    bytes = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h54, 8'h65};
    wait_idle();
    fork
      begin : producer
        int   i = 0;
        int   guard = 0;
        bit   chk5 = 1'b0;
        logic rdy;
        while (i < 6 && guard < 1000) begin
          tx_data  = bytes[i];
          tx_valid = 1'b1;
          rdy      = tx_ready;
          @(posedge clk);
          #1;
          if (rdy) i++;
          @(negedge clk);
          guard++;
          if (i == 5 && !chk5) begin
            chk5 = 1'b1;
            vectors++;
            if (fifo_count !== 3'd4 || tx_ready !== 1'b0) begin
              miscompares++; $display("FAIL full_after_5: count=%0d ready=%b want 4/0", fifo_count, tx_ready);
            end
          end
          if (fifo_count === 3'd4) begin
            vectors++;
            if (tx_ready !== 1'b0) begin miscompares++; $display("FAIL full_ready: ready=%b want 0 at count 4", tx_ready); end
          end
        end
        tx_valid = 1'b0;
        vectors++;
        if (i != 6) begin miscompares++; $display("FAIL full_accept: accepted %0d want 6", i); end
      end
      begin : consumer
        logic [7:0] d;
        logic       p;
        int         s, pk;
        bit         ok;
        for (int k = 0; k < 6; k++) begin
          uart_rx(d, p, s, pk, ok);
          vectors++;
          if (d !== bytes[k] || !ok) begin
            miscompares++; $display("FAIL full_order%0d: got %h ok=%0d want %h", k, d, ok, bytes[k]);
          end
        end
      end
    join
    wait_idle();
    n = 0;
    for (int m = 0; m < 2 * NB * C; m++) begin
      @(negedge clk);
      if (txd !== 1'b1 || tx_busy !== 1'b0) n++;
    end
    vectors++;
    if (n != 0 || fifo_count !== 3'd0) begin
      miscompares++; $display("FAIL full_no_extra: active samples=%0d count=%0d want 0/0", n, fifo_count);
    end
  endtask

  task automatic test_reset_mid_frame();
    int n = 0;
    wait_idle();
    push_byte(8'hA5);
    push_byte(8'hFF);
    repeat (18) @(negedge clk);
    vectors++; if (txd !== 1'b0 || fifo_count !== 3'd1) begin
      miscompares++; $display("FAIL abort_pre: txd=%b count=%0d want 0/1", txd, fifo_count);
    end
    reset_n = 1'b0;
    #1;
    vectors++; if (txd !== 1'b1) begin miscompares++; $display("FAIL abort_txd_async: got %b want 1", txd); end
    vectors++; if (fifo_count !== 3'd0 || tx_ready !== 1'b1 || tx_busy !== 1'b0) begin
      miscompares++; $display("FAIL abort_state: count=%0d ready=%b busy=%b want 0/1/0", fifo_count, tx_ready, tx_busy);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int m = 0; m < 80; m++) begin
      @(negedge clk);
      if (txd !== 1'b1 || tx_busy !== 1'b0) n++;
    end
    vectors++;
    if (n != 0) begin miscompares++; $display("FAIL abort_no_resume: active samples=%0d want 0", n); end
  endtask

  task automatic send_measure(input logic [7:0] b, output logic [7:0] d, output logic par,
                              output bit ok, output int busy_len);
    int s, pk;
    wait_idle();
    push_byte(b);
    fork
      uart_rx(d, par, s, pk, ok);
      begin
        busy_len = 0;
        while (tx_busy === 1'b1 && busy_len < 200) begin
          busy_len++;
          @(negedge clk);
        end
      end
    join
  endtask

  task automatic test_frame_length();
    logic [7:0] d;
    logic       p;
    bit         ok;
    int         len;
    send_measure(8'h07, d, p, ok, len);
    vectors++; if (d !== 8'h07 || !ok) begin miscompares++; $display("FAIL frame07_data: got %h ok=%0d want 07", d, ok); end
    vectors++; if (len !== NB * C + 1) begin miscompares++; $display("FAIL frame07_length: got %0d want %0d", len, NB * C + 1); end
`ifdef PET_UART_TX_PARITY_EN
    vectors++; if (p !== 1'b1) begin miscompares++; $display("FAIL frame07_parity: got %b want 1", p); end
`endif
    send_measure(8'h03, d, p, ok, len);
    vectors++; if (d !== 8'h03 || !ok) begin miscompares++; $display("FAIL frame03_data: got %h ok=%0d want 03", d, ok); end
    vectors++; if (len !== NB * C + 1) begin miscompares++; $display("FAIL frame03_length: got %0d want %0d", len, NB * C + 1); end
`ifdef PET_UART_TX_PARITY_EN
    vectors++; if (p !== 1'b0) begin miscompares++; $display("FAIL frame03_parity: got %b want 0", p); end
`endif
  endtask

  task automatic test_loopback_sweep();
    logic [7:0] d;
    logic       p;
    int         s, pk;
    bit         ok;
    wait_idle();
    for (int b = 0; b < 256; b++) begin
      push_byte(8'(b));
      uart_rx(d, p, s, pk, ok);
      vectors++;
      if (d !== 8'(b) || !ok) begin
        miscompares++; $display("FAIL sweep_%02h: got %h ok=%0d", b, d, ok);
      end
`ifdef PET_UART_TX_PARITY_EN
      vectors++;
      if (p !== ^(8'(b))) begin miscompares++; $display("FAIL sweep_parity_%02h: got %b", b, p); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_single_0x55();
    test_back_to_back();
    test_fifo_full();
    test_reset_mid_frame();
    test_frame_length();
    test_loopback_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
